// File: rtl/exec_if.sv
// exec_if: issue/writeback bundle between the issue logic, exec_stage and the register file.
//   master: drives in_valid/op/dst_adr/src_a/src_b, observes in_ready, wb_*, flags, illegal, busy
//   slave : the execute stage side (exec_stage)
interface exec_if #(parameter int DW = 16, parameter int AW = 2);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [AW-1:0] dst_adr;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic          wb_en;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_data;
  logic          flag_z;
  logic          flag_n;
  logic          flag_c;
  logic          flag_v;
  logic          illegal;
  logic          busy;
  modport master (
    output in_valid, op, dst_adr, src_a, src_b,
    input  in_ready, wb_en, wb_adr, wb_data, flag_z, flag_n, flag_c, flag_v, illegal, busy
  );
  modport slave (
    input  in_valid, op, dst_adr, src_a, src_b,
    output in_ready, wb_en, wb_adr, wb_data, flag_z, flag_n, flag_c, flag_v, illegal, busy
  );
endinterface

// File: rtl/exec_stage.sv
// exec_stage: 16-bit CPU execute stage, single-cycle ALU plus optional iterative shift-add MUL.
//   clk, reset (sync, active-high); bus (exec_if.slave): issue handshake, operands, register
//   file write port (wb_en/wb_adr/wb_data), flags Z/N/C/V, illegal pulse, busy.
//   Define EXEC_STAGE_MUL_EN to build the 16-step MUL; otherwise op 10 is illegal.
module exec_stage #(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input logic   clk,
  input logic   reset,
  exec_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                         OP_MOV = 4'd8, OP_CMP = 4'd9, OP_MUL = 4'd10;
  logic [DW-1:0]   a, b, res;
  logic [DW:0]     sum, dif, shl, shr;
  logic [2*DW-1:0] acc_nx;
  logic [AW-1:0]   mul_dst;
  logic            fire, is_mul, legal, c, v, mul_done;
  assign a     = bus.src_a;
  assign b     = bus.src_b;
  assign fire  = bus.in_valid && bus.in_ready;
  assign sum   = {1'b0, a} + {1'b0, b};
  // top bit of the 17-bit difference is the unsigned borrow (A<B)
  assign dif   = {1'b0, a} - {1'b0, b};
  // the extra bit catches the last bit shifted out; a zero shift leaves it 0
  assign shl   = {1'b0, a} << b[3:0];
  assign shr   = {a, 1'b0} >> b[3:0];
`ifdef EXEC_STAGE_MUL_EN
  localparam bit MUL_EN = 1'b1;
  typedef enum logic {IDLE, MUL} state_t;
  state_t          state, state_nx;
  logic [DW-1:0]   ma, mb;
  logic [3:0]      cnt;
  logic [2*DW-1:0] acc;
  assign bus.in_ready = !reset && state == IDLE;
  assign bus.busy     = state == MUL;
  assign mul_done     = state == MUL && cnt == 4'd15;
  assign acc_nx       = acc + (mb[cnt] ? {{DW{1'b0}}, ma} << cnt : '0);
  always_comb begin
    state_nx = mul_done ? IDLE : (fire && is_mul) ? MUL : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {ma, mb, mul_dst, cnt, acc} <= '0;
    end else if (fire && is_mul) begin
      {ma, mb, mul_dst, cnt, acc} <= {a, b, bus.dst_adr, 4'd0, {2*DW{1'b0}}};
    end else if (state == MUL) begin
      acc <= acc_nx;
      cnt <= cnt + 4'd1;
    end
  end
`else
  localparam bit MUL_EN = 1'b0;
  assign bus.in_ready = !reset;
  assign bus.busy     = 1'b0;
  assign mul_done     = 1'b0;
  assign acc_nx       = '0;
  assign mul_dst      = '0;
`endif
  assign is_mul = MUL_EN && bus.op == OP_MUL;
  assign legal  = bus.op <= OP_CMP || is_mul;
  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        res = sum[DW-1:0];
        c   = sum[DW];
        v   = a[DW-1] == b[DW-1] && res[DW-1] != a[DW-1];
      end
      OP_SUB, OP_CMP: begin
        res = dif[DW-1:0];
        c   = dif[DW];
        v   = a[DW-1] != b[DW-1] && res[DW-1] != a[DW-1];
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: {c, res} = shl;
      OP_SHR: {res, c} = shr;
      OP_MOV: res = b;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wb_en   <= 1'b0;
      bus.wb_adr  <= '0;
      bus.wb_data <= '0;
      bus.illegal <= 1'b0;
      {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} <= 4'b0;
    end else begin
      bus.wb_en   <= 1'b0;
      bus.illegal <= 1'b0;
      if (mul_done) begin
        bus.wb_en   <= 1'b1;
        bus.wb_adr  <= mul_dst;
        bus.wb_data <= acc_nx[DW-1:0];
        {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} <=
          {acc_nx[DW-1:0] == '0, acc_nx[DW-1], |acc_nx[2*DW-1:DW], 1'b0};
      end else if (fire && !is_mul) begin
        if (!legal) begin
          bus.illegal <= 1'b1;
        end else begin
          {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} <= {res == '0, res[DW-1], c, v};
          if (bus.op != OP_CMP) begin
            bus.wb_en   <= 1'b1;
            bus.wb_adr  <= bus.dst_adr;
            bus.wb_data <= res;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed and randomized self-checking bench for exec_stage.
module tb_exec_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  exec_if bus ();
  exec_stage dut (.clk(clk), .reset(reset), .bus(bus));
  wire [25:0] obs = {bus.in_ready, bus.busy, bus.wb_en, bus.wb_adr, bus.wb_data,
                     bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.illegal};
  int n_checks = 0;
  int n_fail = 0;
  logic [1:0]  m_adr;
  logic [15:0] m_data;
  logic [3:0]  m_f;
`ifdef EXEC_STAGE_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif
  typedef struct packed {logic wr; logic ill; logic [15:0] d; logic [3:0] f;} res_t;

  function automatic res_t predict(input int o, input int a, input int b);
    res_t e;
    int sa, sb, r, s, sr;
    longint p;
    bit c, v;
    sa = a >= 32768 ? a - 65536 : a;
    sb = b >= 32768 ? b - 65536 : b;
    s = b % 16;
    r = 0; c = 0; v = 0; sr = 0;
    e.wr = 1; e.ill = 0;
    case (o)
      0: begin r = a + b; c = r > 65535; sr = sa + sb; v = sr > 32767 || sr < -32768; end
      1, 9: begin r = a - b; c = a < b; sr = sa - sb; v = sr > 32767 || sr < -32768; e.wr = o == 1; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 65535 - a;
      6: begin r = a << s; c = s != 0 && ((a >> (16 - s)) & 1) == 1; end
      7: begin r = a >> s; c = s != 0 && ((a >> (s - 1)) & 1) == 1; end
      8: r = b;
      10: begin
        p = longint'(a) * longint'(b);
        r = int'(p % 65536);
        c = p >= 65536;
        e.ill = !MUL_ON;
        e.wr = MUL_ON;
      end
      default: begin e.ill = 1; e.wr = 0; end
    endcase
    r = r & 16'hFFFF;
    e.d = r[15:0];
    e.f = {r == 0, r[15], c, v};
    return e;
  endfunction

  function automatic logic [15:0] pick();
    logic [15:0] t [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    case ($urandom_range(0, 3))
      0: return t[$urandom_range(0, 4)];
      1: return 16'($urandom_range(0, 17));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic issue(input logic [3:0] o, input logic [1:0] d, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.dst_adr = d;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.op = 4'($urandom);
    bus.src_a = 16'($urandom);
    bus.src_b = 16'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.op = 4'd0;
    bus.dst_adr = 2'd0;
    bus.src_a = 16'd0;
    bus.src_b = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 26'd0) begin n_fail++; $display("FAIL reset_hold: got %h want %h", obs, 26'd0); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== {1'b1, 25'd0}) begin n_fail++; $display("FAIL reset_release: got %h want %h", obs, {1'b1, 25'd0}); end
  endtask

  task automatic test_add();
    issue(4'd0, 2'd2, 16'h7FFF, 16'h0001);
    n_checks++;
    if (obs !== {3'b101, 2'd2, 16'h8000, 4'b0101, 1'b0}) begin n_fail++; $display("FAIL add: got %h want %h", obs, {3'b101, 2'd2, 16'h8000, 4'b0101, 1'b0}); end
    idle();
    n_checks++;
    if (obs !== {3'b100, 2'd2, 16'h8000, 4'b0101, 1'b0}) begin n_fail++; $display("FAIL add_hold: got %h want %h", obs, {3'b100, 2'd2, 16'h8000, 4'b0101, 1'b0}); end
  endtask

  task automatic test_back_to_back();
    issue(4'd1, 2'd1, 16'h0003, 16'h0005);
    n_checks++;
    if (obs !== {3'b101, 2'd1, 16'hFFFE, 4'b0110, 1'b0}) begin n_fail++; $display("FAIL sub: got %h want %h", obs, {3'b101, 2'd1, 16'hFFFE, 4'b0110, 1'b0}); end
    issue(4'd9, 2'd3, 16'h0005, 16'h0005);
    n_checks++;
    if (obs !== {3'b100, 2'd1, 16'hFFFE, 4'b1000, 1'b0}) begin n_fail++; $display("FAIL cmp: got %h want %h", obs, {3'b100, 2'd1, 16'hFFFE, 4'b1000, 1'b0}); end
  endtask

  task automatic test_shift();
    issue(4'd6, 2'd0, 16'h8001, 16'h0001);
    n_checks++;
    if (obs !== {3'b101, 2'd0, 16'h0002, 4'b0010, 1'b0}) begin n_fail++; $display("FAIL shl: got %h want %h", obs, {3'b101, 2'd0, 16'h0002, 4'b0010, 1'b0}); end
    issue(4'd7, 2'd3, 16'h0001, 16'h0000);
    n_checks++;
    if (obs !== {3'b101, 2'd3, 16'h0001, 4'b0000, 1'b0}) begin n_fail++; $display("FAIL shr0: got %h want %h", obs, {3'b101, 2'd3, 16'h0001, 4'b0000, 1'b0}); end
  endtask

  task automatic test_illegal();
    issue(4'd1, 2'd1, 16'h0003, 16'h0005);
    issue(4'd13, 2'd2, 16'h1234, 16'h5678);
    n_checks++;
    if (obs !== {3'b100, 2'd1, 16'hFFFE, 4'b0110, 1'b1}) begin n_fail++; $display("FAIL illegal13: got %h want %h", obs, {3'b100, 2'd1, 16'hFFFE, 4'b0110, 1'b1}); end
    idle();
    n_checks++;
    if (obs !== {3'b100, 2'd1, 16'hFFFE, 4'b0110, 1'b0}) begin n_fail++; $display("FAIL illegal_pulse: got %h want %h", obs, {3'b100, 2'd1, 16'hFFFE, 4'b0110, 1'b0}); end
`ifndef EXEC_STAGE_MUL_EN
    issue(4'd10, 2'd0, 16'h0003, 16'h0003);
    n_checks++;
    if (obs !== {3'b100, 2'd1, 16'hFFFE, 4'b0110, 1'b1}) begin n_fail++; $display("FAIL mul_disabled: got %h want %h", obs, {3'b100, 2'd1, 16'hFFFE, 4'b0110, 1'b1}); end
    idle();
`endif
  endtask

`ifdef EXEC_STAGE_MUL_EN
  task automatic test_mul();
    int cnt;
    bit early_wb;
    issue(4'd10, 2'd2, 16'h0100, 16'h0100);
    n_checks++;
    if (obs[25:23] !== 3'b010) begin n_fail++; $display("FAIL mul_busy: got %b want %b", obs[25:23], 3'b010); end
    bus.op = 4'd0;
    bus.dst_adr = 2'd0;
    bus.src_a = 16'h1111;
    cnt = 0;
    early_wb = 0;
    while (!bus.in_ready && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.wb_en && !bus.in_ready) early_wb = 1;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (cnt !== 16 || early_wb) begin n_fail++; $display("FAIL mul_stall: got %0d cycles wb_early=%0d want 16 cycles", cnt, early_wb); end
    n_checks++;
    if (obs !== {3'b101, 2'd2, 16'h0000, 4'b1010, 1'b0}) begin n_fail++; $display("FAIL mul_0x100: got %h want %h", obs, {3'b101, 2'd2, 16'h0000, 4'b1010, 1'b0}); end
    issue(4'd10, 2'd1, 16'd300, 16'd7);
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.in_ready && cnt < 40) begin @(posedge clk); #1; cnt++; end
    n_checks++;
    if (obs !== {3'b101, 2'd1, 16'h0834, 4'b0000, 1'b0}) begin n_fail++; $display("FAIL mul_300x7: got %h want %h", obs, {3'b101, 2'd1, 16'h0834, 4'b0000, 1'b0}); end
  endtask
`endif

  task automatic test_reset_mid();
`ifdef EXEC_STAGE_MUL_EN
    issue(4'd10, 2'd3, 16'h1234, 16'hFFFF);
    repeat (8) idle();
`else
    issue(4'd0, 2'd3, 16'h1234, 16'hFFFF);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 26'd0) begin n_fail++; $display("FAIL reset_mid: got %h want %h", obs, 26'd0); end
    reset = 1'b0;
    repeat (20) idle();
    n_checks++;
    if (obs !== {1'b1, 25'd0}) begin n_fail++; $display("FAIL reset_abort: got %h want %h", obs, {1'b1, 25'd0}); end
  endtask

  task automatic test_random();
    res_t e;
    logic [3:0] o;
    logic [1:0] d;
    logic [15:0] a, b;
    int cnt;
    reset = 1'b1;
    idle();
    reset = 1'b0;
    m_adr = 2'd0;
    m_data = 16'd0;
    m_f = 4'd0;
    for (int i = 0; i < 300; i++) begin
      o = 4'($urandom_range(0, 15));
      d = 2'($urandom);
      a = pick();
      b = pick();
      issue(o, d, a, b);
      bus.in_valid = 1'b0;
      bus.src_a = ~a;
      bus.src_b = ~b;
      cnt = 0;
      while (!bus.in_ready && cnt < 40) begin @(posedge clk); #1; cnt++; end
      if (cnt == 40) begin n_checks++; n_fail++; $display("FAIL rand_timeout: in_ready stuck low after op %0d", o); end
      e = predict(int'(o), int'(a), int'(b));
      if (!e.ill) m_f = e.f;
      if (e.wr) begin m_adr = d; m_data = e.d; end
      n_checks++;
      if (obs !== {2'b10, e.wr, m_adr, m_data, m_f, e.ill}) begin
        n_fail++;
        $display("FAIL rand op=%0d a=%h b=%h: got %h want %h", o, a, b, obs, {2'b10, e.wr, m_adr, m_data, m_f, e.ill});
      end
      if ($urandom_range(0, 2) == 0) begin
        idle();
        n_checks++;
        if (obs !== {3'b100, m_adr, m_data, m_f, 1'b0}) begin n_fail++; $display("FAIL rand_idle: got %h want %h", obs, {3'b100, m_adr, m_data, m_f, 1'b0}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_shift();
    test_illegal();
`ifdef EXEC_STAGE_MUL_EN
    test_mul();
`endif
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the 16-bit CPU. Sits directly downstream of the 4x16 register file.
- Consumes the two read operands plus a decoded opcode and destination address.
- Computes the ALU result, then drives the register file write port (write_en/write_adr/write_data) through its wb_* outputs.
- Single-cycle ops run at full issue rate. MUL is an iterative 16-step shift-add that stalls issue via in_ready.

Parameters:
- DW, 16, datapath width (fixed at 16 for this CPU; other values unsupported)
- AW, 2, register address width (4 registers)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  issue request; op/dst/src fields valid
- in_ready  output  1  stage can accept an issue this cycle
- op  input  4  opcode (see Behaviour)
- dst_adr  input  2  destination register
- src_a  input  16  operand A (register file read_data1)
- src_b  input  16  operand B (register file read_data2)
- wb_en  output  1  one-cycle write pulse to register file write_en
- wb_adr  output  2  write address
- wb_data  output  16  write data
- flag_z / flag_n / flag_c / flag_v  output  1 each  zero, negative, carry/borrow, signed overflow
- illegal  output  1  one-cycle pulse on an unsupported opcode
- busy  output  1  high while a MUL is iterating

Behaviour:
- Reset: all outputs 0; state IDLE; in_ready goes high in the first cycle after reset deasserts. Reset mid-MUL aborts it with no writeback.
- Issue is accepted on an edge where in_valid && in_ready. Operands are sampled only at acceptance, so the register file may change afterwards.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by B[3:0], 7 SHR logical A by B[3:0], 8 MOV B
  - 9 CMP: flags as SUB, no writeback
  - 10 MUL: low 16 bits of A*B unsigned
  - 11-15 illegal
- Single-cycle ops, accepted at edge k:
  - wb_en/wb_adr/wb_data and flags are registered at edge k and visible during cycle k..k+1.
  - wb_en is 1 for exactly that cycle.
  - in_ready stays high, so back-to-back issue is allowed (one result per cycle).
- Flags:
  - Z = result==0; N = result[15].
  - ADD: C = carry out; V = signed overflow.
  - SUB/CMP: C = 1 iff A<B unsigned (borrow); V = signed overflow.
  - AND/OR/XOR/NOT/MOV: C=V=0.
  - Shifts: C = last bit shifted out; shift amount 0 gives C=0 and result=A; V=0.
- Flags hold their value between updates and are not affected by an illegal opcode.
- Illegal opcode: no writeback, flags unchanged, illegal=1 for one cycle after the acceptance edge.
- FSM states:
  - IDLE: accepts issues. MUL issue goes to MUL; every other op stays in IDLE.
  - MUL: in_ready=0, busy=1. Latches A, B, dst; 4-bit step counter starts at 0. Each edge adds (B[i] ? A<<i : 0) into a 32-bit accumulator.
  - After the step with counter==15 (edge k+16): result and flags registered, wb_en=1 for cycle k+16..k+17, state returns to IDLE, in_ready=1 in that same cycle.
- MUL flags: Z/N from the low 16 bits; C = |product[31:16]; V=0.
- in_valid while in_ready=0 is ignored; upstream must hold the request.
- wb_en is never asserted for CMP or illegal ops. wb_adr/wb_data hold their last values when wb_en=0.

Optional Feature:
- Macro: EXEC_STAGE_MUL_EN
- Defined: MUL (op 10) behaves as described, including the multi-cycle FSM.
- Undefined: the MUL state and accumulator are not built. Op 10 is treated as illegal (illegal pulse, no writeback). busy is tied 0 and in_ready is tied 1 out of reset.

Test Plan:
- Reset, then ADD A=0x7FFF B=0x0001 dst=2 -> next cycle wb_en=1, wb_adr=2, wb_data=0x8000, N=1, V=1, C=0, Z=0.
- SUB A=0x0003 B=0x0005, then CMP A=5 B=5 back-to-back -> SUB: wb_data=0xFFFE, C=1, N=1. CMP: no wb_en, Z=1, C=0.
- SHL A=0x8001 B=1 -> wb_data=0x0002, C=1. SHR A=0x0001 B=0 -> wb_data=0x0001, C=0.
- MUL A=0x0100 B=0x0100 (EXEC_STAGE_MUL_EN defined) -> in_ready low 16 cycles, in_valid pulses ignored, then wb_data=0x0000, Z=1, C=1. MUL 300*7 -> wb_data=0x0834.
- Reset asserted at MUL step 8 -> no wb_en, busy=0, all outputs 0, in_ready=1 after reset.
- Op 13, and op 10 with macro undefined -> illegal pulse 1 cycle, no wb_en, flags unchanged from prior op.
